// File: rtl/sort_vec_serializer_pkg.sv
// Shared types and defaults for the sort-network output path.
// Used by sort_vec_serializer and sort_lane_mux.
package sort_pkg;
  localparam int DATA_W = 32;
  localparam int SORT_N = 10;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } ser_state_t;
endpackage

// File: rtl/sort_vec_serializer_lane_mux.sv
// Combinational N-to-1 lane selector over a flattened vector.
// The select is an AND-OR tree, so out-of-range selects return zero.
module sort_lane_mux
  import sort_pkg::*;
#(
  parameter int N  = SORT_N,
  parameter int W  = DATA_W,
  parameter int IW = $clog2(N)
) (
  input  logic [N*W-1:0] i_vec,
  input  logic [IW-1:0]  i_sel,
  output logic [W-1:0]   o_data
);

  // one-hot AND-OR selection of the addressed lane
  always_comb begin
    o_data = '0;
    for (int k = 0; k < N; k++) begin
      o_data = o_data | ({W{i_sel == IW'(k)}} & i_vec[k*W +: W]);
    end
  end

endmodule

// File: rtl/sort_vec_serializer.sv
// Captures one sorted N-lane vector and streams it out one lane per beat,
// tagging median and last beats. Optional ordering monitor: SORT_ORDER_CHECK_EN.
module sort_vec_serializer
  import sort_pkg::*;
#(
  parameter int N       = SORT_N,
  parameter int W       = DATA_W,
  parameter bit REVERSE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*W-1:0]       in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_median,
  output logic                 out_last,
  output logic                 err_order
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] FIRST_IDX = REVERSE ? IW'(N-1) : IW'(0);
  localparam logic [IW-1:0] LAST_IDX  = REVERSE ? IW'(0)   : IW'(N-1);
  localparam logic [IW-1:0] MED_IDX   = IW'(N/2);

  ser_state_t     r_state;
  ser_state_t     w_state_nxt;
  logic [IW-1:0]  r_cnt;
  logic [IW-1:0]  w_cnt_nxt;
  logic [N*W-1:0] r_buf;
  logic [W-1:0]   w_mux;
  logic           w_emit;
  logic           w_last;
  logic           w_beat;
  logic           w_cap;

  assign w_emit = (r_state == EMIT);
  assign w_last = w_emit && (r_cnt == LAST_IDX);
  assign w_beat = w_emit && out_ready;
  assign w_cap  = in_valid && in_ready;

  // next state, beat counter and input-side ready
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = EMIT;
          w_cnt_nxt   = FIRST_IDX;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EMIT: begin
        // ready only as the final beat leaves, so a new vector lands with no bubble
        in_ready = w_last && out_ready;
        if (w_beat && w_last) begin
          if (in_valid) begin
            w_state_nxt = EMIT;
            w_cnt_nxt   = FIRST_IDX;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_beat) begin
          w_cnt_nxt = REVERSE ? (r_cnt - IW'(1)) : (r_cnt + IW'(1));
        end else begin
          w_state_nxt = EMIT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // state, counter and vector buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cap) begin
        r_buf <= in_data;
      end
    end
  end

  sort_lane_mux #(
    .N  (N),
    .W  (W),
    .IW (IW)
  ) u_lane_mux (
    .i_vec  (r_buf),
    .i_sel  (r_cnt),
    .o_data (w_mux)
  );

  assign out_valid  = w_emit;
  assign out_data   = w_emit ? w_mux : '0;
  assign out_index  = w_emit ? r_cnt : '0;
  assign out_median = w_emit && (r_cnt == MED_IDX);
  assign out_last   = w_last;

`ifdef SORT_ORDER_CHECK_EN
  logic [W-1:0] r_prev;
  logic         r_err;
  logic         w_viol;

  // the first beat of each vector has no predecessor to compare against
  assign w_viol = w_beat && (r_cnt != FIRST_IDX) &&
                  (REVERSE ? (w_mux > r_prev) : (w_mux < r_prev));

  // previous emitted element and sticky violation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_beat) begin
        r_prev <= w_mux;
      end
      if (w_viol) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_order = r_err;
`else
  assign err_order = 1'b0;
`endif

endmodule
